// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Holds ALUOp encodings, primary opcodes, the default data and register
// specifier widths, and the rt-usage helper used by hazard detection.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b11
  } aluOp_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // rt is a source for R-type and beq (register operand, no immediate)
  // and for sw (store data), even though sw selects the immediate.
  function automatic logic usesRt(input logic aluSrc, input logic memWrite);
    return !aluSrc || memWrite;
  endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID -> EX boundary bundle.
// master: decode side / hazard consumer (drives ID fields, flush, hold;
//         receives the EX copy, stall and bubble count).
// slave : the ID/EX register itself.
interface id_ex_pipe_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 16
);

  logic              id_valid_i;
  logic              reg_dst_i;
  logic              alu_src_i;
  logic              reg_write_i;
  logic              mem_to_reg_i;
  logic              mem_write_i;
  logic [1:0]        alu_op_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_W-1:0]  rs_i;
  logic [REG_W-1:0]  rt_i;
  logic [REG_W-1:0]  rd_i;
  logic              flush_i;
  logic              hold_i;

  logic              ex_valid_o;
  logic              ex_reg_dst_o;
  logic              ex_alu_src_o;
  logic              ex_reg_write_o;
  logic              ex_mem_to_reg_o;
  logic              ex_mem_write_o;
  logic [1:0]        ex_alu_op_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_W-1:0]  ex_rs_o;
  logic [REG_W-1:0]  ex_rt_o;
  logic [REG_W-1:0]  ex_rd_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubbles_o;

  modport master (
    output id_valid_i, reg_dst_i, alu_src_i, reg_write_i, mem_to_reg_i,
           mem_write_i, alu_op_i, rs_data_i, rt_data_i, imm_i,
           rs_i, rt_i, rd_i, flush_i, hold_i,
    input  ex_valid_o, ex_reg_dst_o, ex_alu_src_o, ex_reg_write_o,
           ex_mem_to_reg_o, ex_mem_write_o, ex_alu_op_o, ex_rs_data_o,
           ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           stall_o, bubbles_o
  );

  modport slave (
    input  id_valid_i, reg_dst_i, alu_src_i, reg_write_i, mem_to_reg_i,
           mem_write_i, alu_op_i, rs_data_i, rt_data_i, imm_i,
           rs_i, rt_i, rd_i, flush_i, hold_i,
    output ex_valid_o, ex_reg_dst_o, ex_alu_src_o, ex_reg_write_o,
           ex_mem_to_reg_o, ex_mem_write_o, ex_alu_op_o, ex_rs_data_o,
           ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o,
           stall_o, bubbles_o
  );

endinterface

// File: rtl/id_ex_pipe_load_use_detect.sv
// Combinational load-use detector.
// Inputs : EX-stage load state (valid, mem_to_reg, rt) and the ID
//          instruction's valid flag, rs/rt specifiers, alu_src, mem_write.
// Output : lu, high when the ID instruction reads the register the EX
//          load is about to write. $0 never creates a dependence.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int SPEC_W = mips_pkg::REG_W
) (
  input  logic              exValid,
  input  logic              exMemToReg,
  input  logic [SPEC_W-1:0] exRt,
  input  logic              idValid,
  input  logic [SPEC_W-1:0] idRs,
  input  logic [SPEC_W-1:0] idRt,
  input  logic              idAluSrc,
  input  logic              idMemWrite,
  output logic              lu
);

  logic loadPending;
  logic rsHit;
  logic rtHit;

  assign loadPending = exValid && exMemToReg && (exRt != '0) && idValid;
  assign rsHit       = (exRt == idRs);
  assign rtHit       = (exRt == idRt) && usesRt(idAluSrc, idMemWrite);
  assign lu          = loadPending && (rsHit || rtHit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous reset, active-high
//   pipe   - id_ex_pipe_if.slave: ID fields, flush/hold in; EX copy,
//            stall and saturating bubble count out
// Update priority per edge: reset > hold > flush > load-use bubble > load.
module id_ex_pipe #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_W  = mips_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  id_ex_pipe_if.slave  pipe
);

  logic              exValid;
  logic              exRegDst;
  logic              exAluSrc;
  logic              exRegWrite;
  logic              exMemToReg;
  logic              exMemWrite;
  logic [1:0]        exAluOp;
  logic [DATA_W-1:0] exRsData;
  logic [DATA_W-1:0] exRtData;
  logic [DATA_W-1:0] exImm;
  logic [REG_W-1:0]  exRs;
  logic [REG_W-1:0]  exRt;
  logic [REG_W-1:0]  exRd;
  logic [CNT_W-1:0]  bubbleCnt;
  logic              lu;
  logic              ctlEn;

  load_use_detect #(.SPEC_W(REG_W)) uLoadUse (
    .exValid    (exValid),
    .exMemToReg (exMemToReg),
    .exRt       (exRt),
    .idValid    (pipe.id_valid_i),
    .idRs       (pipe.rs_i),
    .idRt       (pipe.rt_i),
    .idAluSrc   (pipe.alu_src_i),
    .idMemWrite (pipe.mem_write_i),
    .lu         (lu)
  );

  // Invalid ID slots still carry their data, but their control bits are
  // cleared so they can never write the register file or memory.
  assign ctlEn = pipe.id_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exValid    <= 1'b0;
      exRegDst   <= 1'b0;
      exAluSrc   <= 1'b0;
      exRegWrite <= 1'b0;
      exMemToReg <= 1'b0;
      exMemWrite <= 1'b0;
      exAluOp    <= '0;
      exRsData   <= '0;
      exRtData   <= '0;
      exImm      <= '0;
      exRs       <= '0;
      exRt       <= '0;
      exRd       <= '0;
      bubbleCnt  <= '0;
    end else if (!pipe.hold_i) begin
      if (pipe.flush_i || lu) begin
        exValid    <= 1'b0;
        exRegDst   <= 1'b0;
        exAluSrc   <= 1'b0;
        exRegWrite <= 1'b0;
        exMemToReg <= 1'b0;
        exMemWrite <= 1'b0;
        exAluOp    <= '0;
        exRsData   <= '0;
        exRtData   <= '0;
        exImm      <= '0;
        exRs       <= '0;
        exRt       <= '0;
        exRd       <= '0;
        // Only hazard bubbles are counted; a flush that coincides with a
        // load-use hides it.
        if (!pipe.flush_i && (bubbleCnt != '1)) begin
          bubbleCnt <= bubbleCnt + CNT_W'(1);
        end
      end else begin
        exValid    <= pipe.id_valid_i;
        exRegDst   <= pipe.reg_dst_i    && ctlEn;
        exAluSrc   <= pipe.alu_src_i    && ctlEn;
        exRegWrite <= pipe.reg_write_i  && ctlEn;
        exMemToReg <= pipe.mem_to_reg_i && ctlEn;
        exMemWrite <= pipe.mem_write_i  && ctlEn;
        exAluOp    <= ctlEn ? pipe.alu_op_i : 2'b00;
        exRsData   <= pipe.rs_data_i;
        exRtData   <= pipe.rt_data_i;
        exImm      <= pipe.imm_i;
        exRs       <= pipe.rs_i;
        exRt       <= pipe.rt_i;
        exRd       <= pipe.rd_i;
      end
    end
  end

  assign pipe.ex_valid_o      = exValid;
  assign pipe.ex_reg_dst_o    = exRegDst;
  assign pipe.ex_alu_src_o    = exAluSrc;
  assign pipe.ex_reg_write_o  = exRegWrite;
  assign pipe.ex_mem_to_reg_o = exMemToReg;
  assign pipe.ex_mem_write_o  = exMemWrite;
  assign pipe.ex_alu_op_o     = exAluOp;
  assign pipe.ex_rs_data_o    = exRsData;
  assign pipe.ex_rt_data_o    = exRtData;
  assign pipe.ex_imm_o        = exImm;
  assign pipe.ex_rs_o         = exRs;
  assign pipe.ex_rt_o         = exRt;
  assign pipe.ex_rd_o         = exRd;
  assign pipe.stall_o         = lu || pipe.hold_i;
  assign pipe.bubbles_o       = bubbleCnt;

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

ID/EX pipeline register with integrated load-use hazard detection for the pipelined MIPS core. It sits directly downstream of the decode-stage control unit and register file. It captures decoded control bits, operands and register specifiers each cycle and presents them to the EX stage. It also detects load-use hazards, which stall IF/ID and insert a bubble, and honours external flush and hold requests.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- id_valid_i  in  1  ID holds a real instruction
- reg_dst_i, alu_src_i, reg_write_i, mem_to_reg_i, mem_write_i  in  1 each  decoded control bits
- alu_op_i  in  2  ALU operation class
- rs_data_i, rt_data_i, imm_i  in  DATA_W  operands, sign-extended immediate
- rs_i, rt_i, rd_i  in  REG_W  register specifiers
- flush_i  in  1  squash the instruction entering EX (taken branch/jump)
- hold_i  in  1  downstream stall; freeze the register
- ex_* outputs  out  same widths as the inputs above  registered copies; plus ex_valid_o (1)
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubbles_o  out  CNT_W  count of inserted bubbles, saturating

## Operation
- Register update priority on each clock edge: rst_i > hold_i > flush_i > load-use bubble > normal load.
- Load-use condition `lu`:
  - Asserted when ex_valid_o && ex_mem_to_reg_o && ex_rt_o != 0 && id_valid_i, and either:
    - ex_rt_o == rs_i, or
    - ex_rt_o == rt_i && uses_rt, where uses_rt = !alu_src_i || mem_write_i (R-type, beq, sw).
- stall_o = lu || hold_i. It is combinational from the current ex_* state and the ID inputs.
- hold_i: all ex_* registers and bubbles_o are unchanged.
- flush_i, with hold_i low: load a bubble. bubbles_o does not increment.
- lu, with hold_i and flush_i low: load a bubble. bubbles_o increments by 1 and saturates at all-ones.
- Bubble contents: ex_valid_o = 0, and every control, data and specifier output = 0.
- Normal load: every ex_* output takes its ID input; ex_valid_o = id_valid_i.
- When id_valid_i = 0 on a normal load, the data fields are still captured. The control bits are forced to 0 so invalid slots can never write.

## Timing
- Reset: every ex_* output = 0, ex_valid_o = 0, bubbles_o = 0. Reset takes effect on the first edge with rst_i high.
- Reset mid-stall drops the pending load-use. stall_o falls in the cycle after reset because ex_valid_o is then 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use produces exactly one stall cycle:
  - Cycle N: lu = 1 and stall_o = 1; a bubble is captured at the edge.
  - Cycle N+1: ex_valid_o = 0, so lu = 0; the held consumer is loaded at the edge.
- flush_i together with lu: the flush wins. The bubble counter does not increment, but stall_o is still 1 that cycle.
- hold_i together with lu: the register freezes. stall_o = 1. lu is re-evaluated next cycle.
- Back-to-back loads into dependent consumers stall once per dependence.

## Structure
- Shared package `mips_pkg`: ALUOp encodings (2'b00 add, 2'b01 sub, 2'b11 R-type funct), opcode constants (R 6'h00, addi 6'h08, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02), REG_W, DATA_W.
- One sub-module, `load_use_detect`: purely combinational. It takes the EX load state and the ID specifiers and produces lu.
- The top level is the register bank, the priority mux and the saturating counter.

## Test plan
- Reset then idle: rst_i high for 2 cycles → all ex_* = 0, bubbles_o = 0, stall_o = 0.
- Normal flow: addi (rt=8, imm=5, alu_src=1, reg_write=1), then add rd=9 → ex_* match the inputs one cycle later; stall_o stays 0.
- Load-use: lw rt=8 in EX, then add rs=8 in ID:
  - stall_o = 1 for exactly one cycle.
  - Next cycle ex_valid_o = 0 and bubbles_o = 1.
  - The cycle after, the add appears with rs = 8.
- No false hazard:
  - lw rt=0 followed by a use of $0 → no stall.
  - lw rt=8 followed by addi rt=8 (rt not a source) → no stall.
- flush_i coinciding with lu → bubble loaded, bubbles_o unchanged, stall_o = 1.
- Saturation and hold:
  - Preload bubbles_o at 16'hFFFF, then trigger lu → bubbles_o stays 16'hFFFF.
  - Assert hold_i for 3 cycles → ex_* frozen and stall_o = 1 throughout.
